// File: rtl/dec_down_timer.sv
// Purpose : four-digit BCD MM:SS countdown timer with preset load, start/pause and alarm.
// Latency : digits and state update one clk after the en_i/start/load cycle; zero is combinational.
// Backpressure: none; strobes are consumed in the cycle they are high (init > load > start > en_i).
//
// Ports:
//   clk, init           clock and asynchronous active-high reset
//   en_i                1 Hz decrement strobe (one clk wide)
//   load, ld_*          preset-load strobe and preset digits (clamped on load)
//   start               start/pause toggle strobe (one clk wide)
//   min_h..sec_l        current digits, BCD
//   running / alarm     high in RUN / DONE
//   done_o              one-cycle pulse on entry to DONE
//   zero                high when all four digits are 0
module dec_down_timer #(
  parameter logic [3:0] p_sec_h_max = 4'd5,
  parameter logic [3:0] p_dig_max   = 4'd9
) (
  input  logic       clk,
  input  logic       init,
  input  logic       en_i,
  input  logic       load,
  input  logic [3:0] ld_min_h,
  input  logic [3:0] ld_min_l,
  input  logic [3:0] ld_sec_h,
  input  logic [3:0] ld_sec_l,
  input  logic       start,
  output logic [3:0] min_h,
  output logic [3:0] min_l,
  output logic [3:0] sec_h,
  output logic [3:0] sec_l,
  output logic       running,
  output logic       alarm,
  output logic       done_o,
  output logic       zero
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] min_h_q, min_h_d;
  logic [3:0] min_l_q, min_l_d;
  logic [3:0] sec_h_q, sec_h_d;
  logic [3:0] sec_l_q, sec_l_d;
  logic       done_q, done_d;
  logic       one_left;

  function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] mx);
    return (v > mx) ? mx : v;
  endfunction

  assign zero     = (min_h_q == 4'd0) && (min_l_q == 4'd0) &&
                    (sec_h_q == 4'd0) && (sec_l_q == 4'd0);
  // 00:01 is the last decrementable value; its tick also ends the count.
  assign one_left = (min_h_q == 4'd0) && (min_l_q == 4'd0) &&
                    (sec_h_q == 4'd0) && (sec_l_q == 4'd1);

  always_comb begin
    state_d = state_q;
    min_h_d = min_h_q;
    min_l_d = min_l_q;
    sec_h_d = sec_h_q;
    sec_l_d = sec_l_q;
    done_d  = 1'b0;

    if (load) begin
      min_h_d = clamp(ld_min_h, p_dig_max);
      min_l_d = clamp(ld_min_l, p_dig_max);
      sec_h_d = clamp(ld_sec_h, p_sec_h_max);
      sec_l_d = clamp(ld_sec_l, p_dig_max);
      state_d = ST_IDLE;
    end else if (start) begin
      unique case (state_q)
        ST_IDLE:  if (!zero) state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end else if (en_i && (state_q == ST_RUN) && !zero) begin
      // Borrow ripples sec_l -> sec_h -> min_l -> min_h within one edge.
      if (sec_l_q == 4'd0) begin
        sec_l_d = p_dig_max;
        if (sec_h_q == 4'd0) begin
          sec_h_d = p_sec_h_max;
          if (min_l_q == 4'd0) begin
            min_l_d = p_dig_max;
            min_h_d = min_h_q - 4'd1;
          end else begin
            min_l_d = min_l_q - 4'd1;
          end
        end else begin
          sec_h_d = sec_h_q - 4'd1;
        end
      end else begin
        sec_l_d = sec_l_q - 4'd1;
      end
      if (one_left) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state_q <= ST_IDLE;
      min_h_q <= 4'd0;
      min_l_q <= 4'd0;
      sec_h_q <= 4'd0;
      sec_l_q <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      min_h_q <= min_h_d;
      min_l_q <= min_l_d;
      sec_h_q <= sec_h_d;
      sec_l_q <= sec_l_d;
      done_q  <= done_d;
    end
  end

  assign min_h   = min_h_q;
  assign min_l   = min_l_q;
  assign sec_h   = sec_h_q;
  assign sec_l   = sec_l_q;
  assign running = (state_q == ST_RUN);
  assign alarm   = (state_q == ST_DONE);
  assign done_o  = done_q;

endmodule

// File: tb/tb_dec_down_timer.sv
// Bench for dec_down_timer: directed scenarios plus a randomized run against a
// reference model that tracks the remaining time as a plain count of seconds.
module tb_dec_down_timer;

  logic       clk = 1'b0;
  logic       init;
  logic       en_i, load, start;
  logic [3:0] ld_min_h, ld_min_l, ld_sec_h, ld_sec_l;
  logic [3:0] min_h, min_l, sec_h, sec_l;
  logic       running, alarm, done_o, zero;

  int errors = 0;
  int checks = 0;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_t;      // remaining time in seconds
  int m_st;
  bit m_done;

  dec_down_timer dut (
    .clk(clk), .init(init), .en_i(en_i), .load(load),
    .ld_min_h(ld_min_h), .ld_min_l(ld_min_l), .ld_sec_h(ld_sec_h), .ld_sec_l(ld_sec_l),
    .start(start),
    .min_h(min_h), .min_l(min_l), .sec_h(sec_h), .sec_l(sec_l),
    .running(running), .alarm(alarm), .done_o(done_o), .zero(zero)
  );

  initial forever #5 clk = ~clk;

  function automatic int clampv(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic logic [15:0] m_digits();
    int mins, secs;
    logic [15:0] r;
    mins = m_t / 60;
    secs = m_t % 60;
    r[15:12] = 4'(mins / 10);
    r[11:8]  = 4'(mins % 10);
    r[7:4]   = 4'(secs / 10);
    r[3:0]   = 4'(secs % 10);
    return r;
  endfunction

  task automatic m_reset();
    m_t = 0; m_st = M_IDLE; m_done = 0;
  endtask

  task automatic m_apply(input bit e, input bit l, input bit s,
                         input int a, input int b, input int c, input int d);
    m_done = 0;
    if (l) begin
      m_t  = (clampv(a, 9) * 10 + clampv(b, 9)) * 60 + clampv(c, 5) * 10 + clampv(d, 9);
      m_st = M_IDLE;
    end else if (s) begin
      case (m_st)
        M_IDLE:  if (m_t != 0) m_st = M_RUN;
        M_RUN:   m_st = M_PAUSE;
        M_PAUSE: m_st = M_RUN;
        default: m_st = M_IDLE;
      endcase
    end else if (e && m_st == M_RUN && m_t > 0) begin
      m_t = m_t - 1;
      if (m_t == 0) begin
        m_st = M_DONE;
        m_done = 1;
      end
    end
  endtask

  // One clock cycle of stimulus; returns 1 ns after the edge, strobes cleared.
  task automatic cyc(input bit e, input bit l, input bit s,
                     input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] c, input logic [3:0] d);
    en_i = e; load = l; start = s;
    ld_min_h = a; ld_min_l = b; ld_sec_h = c; ld_sec_l = d;
    @(posedge clk);
    m_apply(e, l, s, int'(a), int'(b), int'(c), int'(d));
    #1;
    en_i = 1'b0; load = 1'b0; start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0);
  endtask

  task automatic test_reset();
    init = 1'b1; en_i = 0; load = 0; start = 0;
    ld_min_h = 0; ld_min_l = 0; ld_sec_h = 0; ld_sec_l = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({min_h, min_l, sec_h, sec_l} !== 16'h0000) begin errors++; $display("FAIL reset_digits got=%h want=0000", {min_h, min_l, sec_h, sec_l}); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got=%b want=0", running); end
    checks++; if (alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm got=%b want=0", alarm); end
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done_o); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got=%b want=1", zero); end
    init = 1'b0;
  endtask

  task automatic test_countdown();
    logic [15:0] want;
    cyc(0, 1, 0, 4'd0, 4'd0, 4'd0, 4'd3);
    checks++; if ({min_h, min_l, sec_h, sec_l} !== 16'h0003) begin errors++; $display("FAIL cd_load got=%h want=0003", {min_h, min_l, sec_h, sec_l}); end
    cyc(0, 0, 1, 4'd0, 4'd0, 4'd0, 4'd0);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL cd_running got=%b want=1", running); end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) idle(9);
      cyc(1, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0);
      want = 16'(2 - k);
      checks++; if ({min_h, min_l, sec_h, sec_l} !== want) begin errors++; $display("FAIL cd_tick%0d got=%h want=%h", k, {min_h, min_l, sec_h, sec_l}, want); end
      checks++; if (done_o !== (k == 2)) begin errors++; $display("FAIL cd_done%0d got=%b want=%b", k, done_o, (k == 2)); end
    end
    checks++; if ({running, alarm, zero} !== 3'b011) begin errors++; $display("FAIL cd_flags got=%b want=011", {running, alarm, zero}); end
    idle(1);
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL cd_done_pulse got=%b want=0", done_o); end
    checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL cd_alarm_hold got=%b want=1", alarm); end
  endtask

  task automatic test_borrow();
    cyc(0, 1, 0, 4'd1, 4'd0, 4'd0, 4'd0);
    cyc(0, 0, 1, 4'd0, 4'd0, 4'd0, 4'd0);
    cyc(1, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0);
    checks++; if ({min_h, min_l, sec_h, sec_l} !== 16'h0959) begin errors++; $display("FAIL borrow_chain got=%h want=0959", {min_h, min_l, sec_h, sec_l}); end
    idle(2);
    cyc(1, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0);
    checks++; if ({min_h, min_l, sec_h, sec_l} !== 16'h0958) begin errors++; $display("FAIL borrow_next got=%h want=0958", {min_h, min_l, sec_h, sec_l}); end
  endtask

  task automatic test_pause();
    cyc(0, 1, 0, 4'd0, 4'd0, 4'd0, 4'd5);
    cyc(0, 0, 1, 4'd0, 4'd0, 4'd0, 4'd0);
    cyc(1, 0, 1, 4'd0, 4'd0, 4'd0, 4'd0);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL pause_state got=%b want=0", running); end
    checks++; if ({min_h, min_l, sec_h, sec_l} !== 16'h0005) begin errors++; $display("FAIL pause_coincident got=%h want=0005", {min_h, min_l, sec_h, sec_l}); end
    cyc(1, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0);
    idle(3);
    cyc(1, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0);
    checks++; if ({min_h, min_l, sec_h, sec_l} !== 16'h0005) begin errors++; $display("FAIL pause_hold got=%h want=0005", {min_h, min_l, sec_h, sec_l}); end
    cyc(0, 0, 1, 4'd0, 4'd0, 4'd0, 4'd0);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL pause_resume got=%b want=1", running); end
    cyc(1, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0);
    checks++; if ({min_h, min_l, sec_h, sec_l} !== 16'h0004) begin errors++; $display("FAIL pause_tick got=%h want=0004", {min_h, min_l, sec_h, sec_l}); end
  endtask

  task automatic test_clamp();
    cyc(0, 1, 0, 4'd0, 4'd1, 4'd7, 4'hC);
    checks++; if ({min_h, min_l, sec_h, sec_l} !== 16'h0159) begin errors++; $display("FAIL clamp_load got=%h want=0159", {min_h, min_l, sec_h, sec_l}); end
    cyc(0, 1, 0, 4'hF, 4'hA, 4'h6, 4'hF);
    checks++; if ({min_h, min_l, sec_h, sec_l} !== 16'h9959) begin errors++; $display("FAIL clamp_max got=%h want=9959", {min_h, min_l, sec_h, sec_l}); end
    #2 init = 1'b1;
    #2 init = 1'b0;
    m_reset();
    cyc(0, 0, 1, 4'd0, 4'd0, 4'd0, 4'd0);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL zero_start_running got=%b want=0", running); end
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0);
      checks++; if ({done_o, alarm, zero} !== 3'b001) begin errors++; $display("FAIL zero_start_flags%0d got=%b want=001", i, {done_o, alarm, zero}); end
    end
  endtask

  task automatic test_async_reset();
    cyc(0, 1, 0, 4'd0, 4'd2, 4'd3, 4'd0);
    cyc(0, 0, 1, 4'd0, 4'd0, 4'd0, 4'd0);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL arst_pre_running got=%b want=1", running); end
    #2 init = 1'b1;
    #1;
    checks++; if ({min_h, min_l, sec_h, sec_l} !== 16'h0000) begin errors++; $display("FAIL arst_digits got=%h want=0000", {min_h, min_l, sec_h, sec_l}); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL arst_running got=%b want=0", running); end
    m_reset();
    #2 init = 1'b0;
    cyc(1, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0);
    checks++; if ({min_h, min_l, sec_h, sec_l, running} !== 17'h0) begin errors++; $display("FAIL arst_tick got=%h want=00000", {min_h, min_l, sec_h, sec_l, running}); end
  endtask

  task automatic test_done_load();
    cyc(0, 1, 0, 4'd0, 4'd0, 4'd0, 4'd1);
    cyc(0, 0, 1, 4'd0, 4'd0, 4'd0, 4'd0);
    cyc(1, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0);
    checks++; if (alarm !== 1'b1) begin errors++; $display("FAIL dl_alarm got=%b want=1", alarm); end
    cyc(0, 1, 1, 4'd0, 4'd0, 4'd1, 4'd0);
    checks++; if ({min_h, min_l, sec_h, sec_l} !== 16'h0010) begin errors++; $display("FAIL dl_digits got=%h want=0010", {min_h, min_l, sec_h, sec_l}); end
    checks++; if ({alarm, running} !== 2'b00) begin errors++; $display("FAIL dl_flags got=%b want=00", {alarm, running}); end
  endtask

  task automatic test_random();
    bit e, l, s;
    logic [3:0] a, b, c, d;
    for (int i = 0; i < 1500; i++) begin
      l = ($urandom_range(0, 99) < 4);
      s = ($urandom_range(0, 99) < 8);
      e = ($urandom_range(0, 99) < 40);
      if ($urandom_range(0, 3) == 0) begin
        a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15));
      end else begin
        a = 4'd0; b = 4'($urandom_range(0, 1));
      end
      c = 4'($urandom_range(0, 15));
      d = 4'($urandom_range(0, 15));
      cyc(e, l, s, a, b, c, d);
      checks++; if ({min_h, min_l, sec_h, sec_l} !== m_digits()) begin errors++; $display("FAIL rand_digits cyc=%0d got=%h want=%h", i, {min_h, min_l, sec_h, sec_l}, m_digits()); end
      checks++; if ({running, alarm, done_o, zero} !== {m_st == M_RUN, m_st == M_DONE, m_done, m_t == 0}) begin errors++; $display("FAIL rand_flags cyc=%0d got=%b want=%b", i, {running, alarm, done_o, zero}, {m_st == M_RUN, m_st == M_DONE, m_done, m_t == 0}); end
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_borrow();
    test_pause();
    test_clamp();
    test_async_reset();
    test_done_load();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
